// File: rtl/fft4_input_reorder.sv
//------------------------------------------------------------------------------
// Module      : fft4_input_reorder
// Description : Groups a sample stream into 4-point frames and presents each
//               frame in bit-reversed order from ping-pong register banks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fft4_input_reorder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_first,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_x0,
  output logic [WIDTH-1:0] out_x1,
  output logic [WIDTH-1:0] out_x2,
  output logic [WIDTH-1:0] out_x3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_drop
);

  localparam logic [1:0] c_last_idx = 2'd3;

  logic [WIDTH-1:0] r_bank [2][4];
  logic [1:0]       r_full;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [1:0]       r_wr_cnt;
  logic             r_frame_drop;

  logic             w_accept;
  logic             w_pop;
  logic [1:0]       w_idx;
  logic [1:0]       w_slot;
  logic             w_done;
  logic [1:0]       w_full_next;

  assign in_ready = !r_full[r_wr_bank];
  assign w_accept = in_valid && in_ready;
  assign w_pop    = r_full[r_rd_bank] && out_ready;
  assign w_idx    = in_first ? 2'd0 : r_wr_cnt;
  // Bit reversal of the two-bit sample index.
  assign w_slot   = {w_idx[0], w_idx[1]};
  assign w_done   = w_accept && (w_idx == c_last_idx);

  // Set and clear never target the same bank, so order is irrelevant.
  always_comb begin
    w_full_next = r_full;
    if (w_done) w_full_next[r_wr_bank] = 1'b1;
    if (w_pop)  w_full_next[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int s = 0; s < 4; s++) begin
          r_bank[b][s] <= '0;
        end
      end
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_wr_cnt     <= 2'd0;
      r_frame_drop <= 1'b0;
    end else begin
      r_full       <= w_full_next;
      r_frame_drop <= w_accept && in_first && (r_wr_cnt != 2'd0);
      if (w_accept) begin
        r_bank[r_wr_bank][w_slot] <= in_data;
        if (w_done) begin
          r_wr_bank <= !r_wr_bank;
          r_wr_cnt  <= 2'd0;
        end else begin
          r_wr_cnt  <= w_idx + 2'd1;
        end
      end
      if (w_pop) r_rd_bank <= !r_rd_bank;
    end
  end

  assign out_valid  = r_full[r_rd_bank];
  assign out_x0     = r_bank[r_rd_bank][0];
  assign out_x1     = r_bank[r_rd_bank][1];
  assign out_x2     = r_bank[r_rd_bank][2];
  assign out_x3     = r_bank[r_rd_bank][3];
  assign frame_drop = r_frame_drop;

endmodule

`default_nettype wire

// File: tb/tb_fft4_input_reorder.sv
//------------------------------------------------------------------------------
// Module      : tb_fft4_input_reorder
// Description : Scoreboard bench for fft4_input_reorder with a frame-level model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft4_input_reorder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_ready;
  logic [31:0] out_x0, out_x1, out_x2, out_x3;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        frame_drop;
  bit          rnd_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0]  part [$];
  logic [127:0] exp_q [$];
  bit           drop_exp = 1'b0;

  fft4_input_reorder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_first(in_first), .in_ready(in_ready), .out_x0(out_x0), .out_x1(out_x1),
    .out_x2(out_x2), .out_x3(out_x3), .out_valid(out_valid),
    .out_ready(out_ready), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: frames are built from accepted samples in arrival order
  // and queued as {x0,x2,x1,x3}; the DUT can hold at most two frames.
  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      exp_q.delete();
      drop_exp = 1'b0;
      chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
      chk("reset_out_x", {out_x0, out_x1, out_x2, out_x3}, 128'd0);
      chk("reset_frame_drop", {127'd0, frame_drop}, 128'd0);
    end else begin
      bit ready_m;
      ready_m = exp_q.size() < 2;
      chk("out_valid", {127'd0, out_valid}, {127'd0, exp_q.size() > 0});
      chk("in_ready", {127'd0, in_ready}, {127'd0, ready_m});
      chk("frame_drop", {127'd0, frame_drop}, {127'd0, drop_exp});
      if (exp_q.size() > 0)
        chk("frame_data", {out_x0, out_x1, out_x2, out_x3}, exp_q[0]);
      drop_exp = 1'b0;
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && ready_m) begin
        if (in_first) begin
          if (part.size() > 0) drop_exp = 1'b1;
          part.delete();
        end
        part.push_back(in_data);
        if (part.size() == 4) begin
          exp_q.push_back({part[0], part[2], part[1], part[3]});
          part.delete();
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic f);
    int t = 0;
    in_data  = d;
    in_first = f;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready || t >= 200) break;
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data %h", d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Basic frame, back-to-back.
    send(32'h00010000, 1'b0);
    send(32'h00020000, 1'b0);
    send(32'h00030000, 1'b0);
    send(32'h00040000, 1'b0);
    cycles(3);

    // Both banks fill, input stalls, then drains in order.
    out_ready = 1'b0;
    fork
      for (int i = 0; i < 12; i++) send(32'h10000000 + i, 1'b0);
      begin cycles(20); out_ready = 1'b1; end
    join
    cycles(4);

    // Partial frame abandoned by in_first.
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'hAAAA0001, 1'b1);
    for (int i = 2; i < 5; i++) send(32'hAAAA0000 + i, 1'b0);
    cycles(3);

    // Sustained streaming.
    for (int i = 0; i < 40; i++) send($urandom, 1'b0);
    cycles(3);

    // Held frame while the next one fills.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h5A000000 + i, 1'b0);
    cycles(5);
    out_ready = 1'b1;
    cycles(4);

    // Reset with one frame held and a partial one pending.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'hC0000000 + i, 1'b0);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycles(1);
    for (int i = 0; i < 4; i++) send(32'hD0000000 + i, 1'b0);
    cycles(3);

    // Randomised traffic.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) cycles(1);
      else send($urandom, ($urandom_range(0, 7) == 0));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    cycles(10);
    chk("drained", {96'd0, 32'(exp_q.size())}, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
